sram_arbiter: RTL
=================

SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 SHALL have parameter STREAK_MAX, default 4: maximum consecutive LSU grants while an IFU request waits.
REQ-002 SHALL have port clk, input, 1: sole clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-004 SHALL have IFU read ports: if_r_addr in 32, if_r_type in 6, if_r_req in 1, if_r_rdy out 1, if_re_data out 64, if_re_valid out 1.
REQ-005 SHALL have LSU read ports: ls_r_addr in 32, ls_r_type in 6, ls_r_req in 1, ls_r_rdy out 1, ls_re_data out 64, ls_re_valid out 1.
REQ-006 SHALL have LSU write ports: ls_w_addr in 32, ls_w_data in 64, ls_w_type in 6, ls_w_strb in 16, ls_w_req in 1, ls_w_rdy out 1.
REQ-007 SHALL have downstream read ports: m_r_addr out 32, m_r_type out 6, m_r_req out 1, m_r_rdy in 1, m_re_data in 64, m_re_valid in 1.
REQ-008 SHALL have downstream write ports: m_w_addr out 32, m_w_data out 64, m_w_type out 6, m_w_strb out 16, m_w_req out 1, m_w_rdy in 1.

Function
REQ-009 SHALL run FSM IDLE, ADDR, RDATA, with at most one downstream transaction outstanding.
REQ-010 IDLE: on any pending request, SHALL latch grant {owner IFU/LSU, is_write} and go to ADDR next cycle; with no request, stay IDLE.
REQ-011 Grant priority SHALL be LSU write > LSU read > IFU read, except IFU wins when streak == STREAK_MAX and if_r_req is high.
REQ-012 streak SHALL increment on each LSU grant made while if_r_req is high, saturate at STREAK_MAX, and clear on any IFU grant.
REQ-013 ADDR: SHALL drive the owner's address, type, data and strobe onto the matching downstream channel, with m_*_req equal to the owner's req.
REQ-014 ADDR: SHALL route m_r_rdy or m_w_rdy only to the owner; non-owner rdy outputs SHALL be 0.
REQ-015 ADDR read, accepted when m_r_req && m_r_rdy: SHALL go to RDATA.
REQ-016 ADDR write, accepted when m_w_req && m_w_rdy: SHALL go to IDLE. Writes are posted, with no data phase.
REQ-017 ADDR: if the owner drops req before accept, SHALL return to IDLE without a downstream transfer.
REQ-018 RDATA: SHALL route m_re_data to both *_re_data, assert only the owner's re_valid on m_re_valid, and go to IDLE that cycle.
REQ-019 SHALL ignore m_re_valid outside RDATA: no re_valid output asserted.
REQ-020 SHALL ignore m_r_rdy and m_w_rdy outside ADDR.
REQ-021 m_r_req and m_w_req SHALL never both be 1; both SHALL be 0 in IDLE and RDATA.
REQ-022 Minimum read latency, request to re_valid, SHALL be 3 cycles with a zero-wait slave. Minimum write latency, request to rdy, SHALL be 2 cycles.
REQ-023 A new grant SHALL NOT be made in the cycle that returns to IDLE; back-to-back transactions are spaced by one IDLE cycle.
REQ-024 The output path from a requester's req to m_*_req SHALL pass through the grant register only.

Reset
REQ-025 While rst is high: FSM=IDLE, grant cleared, streak=0.
REQ-026 While rst is high, all rdy, re_valid and m_*_req outputs SHALL be 0, and data and address outputs 0.
REQ-027 Reset mid-transaction SHALL abandon it: m_*_req low in the first cycle after rst is sampled, and no late re_valid forwarded.

Structure
REQ-028 A shared package SHALL hold the state encoding (IDLE=0, ADDR=1, RDATA=2), the owner enum (IFU=0, LSU=1) and the bus field widths (ADDR 32, DATA 64, TYPE 6, STRB 16).
REQ-029 Priority and streak logic SHALL be one sub-module, sram_arb_prio: combinational pick plus streak counter.

Verification
REQ-030 IFU read to 0x3000_0000, type 3, zero-wait slave returning 0xDEAD_BEEF_0000_1111 -> if_re_valid on cycle 3 with that data; ls_re_valid stays 0.
REQ-031 LSU write 0x1000_0008, data 0x55 and IFU read raised the same cycle -> LSU write granted first, ls_w_rdy pulse; IFU read follows after one IDLE cycle.
REQ-032 STREAK_MAX=4, LSU reads continuously with IFU read pending -> 4 LSU grants, then an IFU grant, then streak=0.
REQ-033 Slave holds m_r_rdy=0 for 5 cycles -> m_r_addr/type held stable and m_r_req=1 throughout; no second grant.
REQ-034 Stray m_re_valid=1 in IDLE -> both re_valid outputs 0; FSM stays IDLE.
REQ-035 rst asserted in RDATA, then m_re_valid=1 -> no re_valid out; all outputs 0; FSM=IDLE.

Source files
------------

// File: rtl/sram_arbiter_pkg.sv
// sram_arbiter_pkg: shared FSM state encoding, requester owner encoding and bus widths
// for the SRAM arbiter and its priority sub-module. No ports.
package sram_arbiter_pkg;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 64;
    localparam int TYPE_W = 6;
    localparam int STRB_W = 16;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ADDR  = 2'd1,
        S_RDATA = 2'd2
    } state_e;

    typedef enum logic {
        OWN_IFU = 1'b0,
        OWN_LSU = 1'b1
    } owner_e;
endpackage

// File: rtl/sram_arb_prio.sv
// sram_arb_prio: grant pick (LSU write > LSU read > IFU read, IFU forced after a full
// LSU streak) plus the saturating streak counter.
// Ports: clk/rst; gnt_en_i (arbiter is in IDLE and may grant); if_req_i, ls_r_req_i,
// ls_w_req_i (pending requests); gnt_vld_o/gnt_own_o/gnt_wr_o (combinational pick).
module sram_arb_prio
    import sram_arbiter_pkg::*;
#(
    parameter int STREAK_MAX = 4
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   gnt_en_i,
    input  logic   if_req_i,
    input  logic   ls_r_req_i,
    input  logic   ls_w_req_i,
    output logic   gnt_vld_o,
    output owner_e gnt_own_o,
    output logic   gnt_wr_o
);
    localparam int SW = $clog2(STREAK_MAX + 1);
    localparam logic [SW-1:0] SMAX = SW'(STREAK_MAX);

    logic [SW-1:0] streak_q, streak_d;
    logic          force_ifu;

    always_comb begin
        // A starved IFU overrides both LSU channels once the streak is full.
        force_ifu = if_req_i && (streak_q == SMAX);
        gnt_vld_o = if_req_i || ls_r_req_i || ls_w_req_i;
        gnt_wr_o  = ls_w_req_i && !force_ifu;
        gnt_own_o = (!force_ifu && (ls_w_req_i || ls_r_req_i)) ? OWN_LSU : OWN_IFU;
        streak_d  = streak_q;
        if (gnt_en_i && gnt_vld_o)
            streak_d = (gnt_own_o == OWN_IFU) ? '0 :
                       (if_req_i && streak_q != SMAX) ? streak_q + 1'b1 : streak_q;
    end

    always_ff @(posedge clk) begin
        if (rst)
            streak_q <= '0;
        else
            streak_q <= streak_d;
    end
endmodule

// File: rtl/sram_arbiter.sv
// sram_arbiter: arbitrates IFU reads, LSU reads and LSU posted writes onto a single
// downstream SRAM port, one transaction outstanding (IDLE -> ADDR -> [RDATA] -> IDLE).
// Ports: clk/rst (sync, active-high); if_r_* IFU read channel; ls_r_* LSU read channel;
// ls_w_* LSU write channel; m_r_* downstream read channel; m_w_* downstream write channel.
// Requester rdy is the downstream rdy routed to the granted owner; re_valid/re_data are
// the downstream read response routed during RDATA.
module sram_arbiter
    import sram_arbiter_pkg::*;
#(
    parameter int STREAK_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] if_r_addr,
    input  logic [TYPE_W-1:0] if_r_type,
    input  logic              if_r_req,
    output logic              if_r_rdy,
    output logic [DATA_W-1:0] if_re_data,
    output logic              if_re_valid,
    input  logic [ADDR_W-1:0] ls_r_addr,
    input  logic [TYPE_W-1:0] ls_r_type,
    input  logic              ls_r_req,
    output logic              ls_r_rdy,
    output logic [DATA_W-1:0] ls_re_data,
    output logic              ls_re_valid,
    input  logic [ADDR_W-1:0] ls_w_addr,
    input  logic [DATA_W-1:0] ls_w_data,
    input  logic [TYPE_W-1:0] ls_w_type,
    input  logic [STRB_W-1:0] ls_w_strb,
    input  logic              ls_w_req,
    output logic              ls_w_rdy,
    output logic [ADDR_W-1:0] m_r_addr,
    output logic [TYPE_W-1:0] m_r_type,
    output logic              m_r_req,
    input  logic              m_r_rdy,
    input  logic [DATA_W-1:0] m_re_data,
    input  logic              m_re_valid,
    output logic [ADDR_W-1:0] m_w_addr,
    output logic [DATA_W-1:0] m_w_data,
    output logic [TYPE_W-1:0] m_w_type,
    output logic [STRB_W-1:0] m_w_strb,
    output logic              m_w_req,
    input  logic              m_w_rdy
);
    state_e state_q, state_d, st;
    owner_e own_q, own_d, gnt_own;
    logic   wr_q, wr_d, gnt_vld, gnt_wr, r_req, own_ifu;

    sram_arb_prio #(.STREAK_MAX(STREAK_MAX)) u_prio (
        .clk        (clk),
        .rst        (rst),
        .gnt_en_i   (st == S_IDLE),
        .if_req_i   (if_r_req),
        .ls_r_req_i (ls_r_req),
        .ls_w_req_i (ls_w_req),
        .gnt_vld_o  (gnt_vld),
        .gnt_own_o  (gnt_own),
        .gnt_wr_o   (gnt_wr)
    );

    always_comb begin
        // Decoding outputs from an effective IDLE state while rst is high forces every
        // output to zero immediately, even before the reset edge lands.
        st          = rst ? S_IDLE : state_q;
        own_ifu     = (own_q == OWN_IFU);
        r_req       = own_ifu ? if_r_req : ls_r_req;
        state_d     = state_q;
        own_d       = own_q;
        wr_d        = wr_q;
        if_r_rdy    = 1'b0;
        ls_r_rdy    = 1'b0;
        ls_w_rdy    = 1'b0;
        if_re_valid = 1'b0;
        ls_re_valid = 1'b0;
        if_re_data  = '0;
        ls_re_data  = '0;
        m_r_addr    = '0;
        m_r_type    = '0;
        m_r_req     = 1'b0;
        m_w_addr    = '0;
        m_w_data    = '0;
        m_w_type    = '0;
        m_w_strb    = '0;
        m_w_req     = 1'b0;
        case (st)
            S_IDLE: begin
                if (gnt_vld) begin
                    state_d = S_ADDR;
                    own_d   = gnt_own;
                    wr_d    = gnt_wr;
                end
            end
            S_ADDR: begin
                // Writes are only ever granted to the LSU, so the write path needs no owner mux.
                if (wr_q) begin
                    m_w_addr = ls_w_addr;
                    m_w_data = ls_w_data;
                    m_w_type = ls_w_type;
                    m_w_strb = ls_w_strb;
                    m_w_req  = ls_w_req;
                    ls_w_rdy = ls_w_req && m_w_rdy;
                    if (!ls_w_req || m_w_rdy)
                        state_d = S_IDLE;
                end else begin
                    m_r_addr = own_ifu ? if_r_addr : ls_r_addr;
                    m_r_type = own_ifu ? if_r_type : ls_r_type;
                    m_r_req  = r_req;
                    if_r_rdy = own_ifu && r_req && m_r_rdy;
                    ls_r_rdy = !own_ifu && r_req && m_r_rdy;
                    state_d  = !r_req ? S_IDLE : m_r_rdy ? S_RDATA : S_ADDR;
                end
            end
            S_RDATA: begin
                if_re_data  = m_re_data;
                ls_re_data  = m_re_data;
                if_re_valid = own_ifu && m_re_valid;
                ls_re_valid = !own_ifu && m_re_valid;
                if (m_re_valid)
                    state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            own_q   <= OWN_IFU;
            wr_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            own_q   <= own_d;
            wr_q    <= wr_d;
        end
    end
endmodule
